// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed decimating FIR.
// The coefficient table is the same one the coefficient ROM is built from.
package fir_pkg;

  localparam int unsigned TAPS_DEFAULT       = 32;
  localparam int unsigned DECIMATION_DEFAULT = 8;
  localparam int unsigned MAC_LAT_DEFAULT    = 2;
  localparam int unsigned COEFF_W            = 16;

  typedef enum logic [2:0] {
    StInit,
    StLoad,
    StMac,
    StDrain,
    StWrite
  } fir_ctrl_state_t;

  // Deliberately asymmetric so a reversed tap walk produces a different sum.
  localparam logic signed [COEFF_W-1:0] COEFFS [TAPS_DEFAULT] = '{
    16'sd5,    -16'sd9,   16'sd14,   16'sd27,   -16'sd41,  16'sd63,   16'sd88,   -16'sd17,
    16'sd120,  16'sd301,  -16'sd77,  16'sd45,   16'sd512,  16'sd233,  -16'sd150, 16'sd99,
    16'sd64,   -16'sd31,  16'sd7,    16'sd180,  -16'sd205, 16'sd11,   16'sd3,    -16'sd2,
    16'sd19,   16'sd72,   -16'sd66,  16'sd38,   16'sd1,    -16'sd13,  16'sd24,   16'sd8
  };

endpackage

// File: rtl/mod_counter.sv
// Wrap-around up counter with synchronous clear; used for pointers and phase counts.
module mod_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequencer for the single-multiplier decimating FIR: zero-fills history, loads
// DECIMATION samples, walks all taps through the MAC, then pushes one result.
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned TAPS       = TAPS_DEFAULT,
  parameter int unsigned DECIMATION = DECIMATION_DEFAULT,
  parameter int unsigned MAC_LAT    = MAC_LAT_DEFAULT,
  parameter int unsigned ADDR_W     = $clog2(TAPS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_empty,
  output logic              x_rd_en,
  output logic              hist_wr_en,
  output logic              hist_wr_zero,
  output logic [ADDR_W-1:0] hist_wr_addr,
  output logic [ADDR_W-1:0] hist_rd_addr,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              mac_en,
  output logic              mac_clr,
  input  logic              y_full,
  output logic              y_wr_en,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LastTap   = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] LastLoad  = ADDR_W'(DECIMATION - 1);
  localparam logic [ADDR_W-1:0] LastDrain = ADDR_W'(MAC_LAT - 1);

  fir_ctrl_state_t state_q, state_d;

  logic [ADDR_W-1:0] head, k, phase_cnt, load_cnt;
  logic              head_en, k_en, k_clr, phase_en, phase_clr, load_en, load_clr;
  logic              pop;

  assign pop = (state_q == StLoad) && !x_empty;

  mod_counter #(.W(ADDR_W)) u_head (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .en    (head_en),
    .count (head)
  );

  mod_counter #(.W(ADDR_W)) u_tap (
    .clock (clock),
    .reset (reset),
    .clr   (k_clr),
    .en    (k_en),
    .count (k)
  );

  // Shared by INIT (zero-fill address) and DRAIN (pipeline wait).
  mod_counter #(.W(ADDR_W)) u_phase (
    .clock (clock),
    .reset (reset),
    .clr   (phase_clr),
    .en    (phase_en),
    .count (phase_cnt)
  );

  mod_counter #(.W(ADDR_W)) u_load (
    .clock (clock),
    .reset (reset),
    .clr   (load_clr),
    .en    (load_en),
    .count (load_cnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (phase_cnt == LastTap) state_d = StLoad;
      StLoad:  if (pop && (load_cnt == LastLoad)) state_d = StMac;
      StMac:   if (k == LastTap) state_d = StDrain;
      StDrain: if (phase_cnt == LastDrain) state_d = StWrite;
      StWrite: if (!y_full) state_d = StLoad;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    x_rd_en      = 1'b0;
    hist_wr_en   = 1'b0;
    hist_wr_zero = 1'b0;
    hist_wr_addr = '0;
    hist_rd_addr = '0;
    coeff_addr   = '0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    y_wr_en      = 1'b0;
    busy         = 1'b1;

    head_en   = pop;
    load_en   = pop;
    load_clr  = pop && (load_cnt == LastLoad);
    k_en      = (state_q == StMac);
    k_clr     = (state_q != StMac);
    phase_en  = (state_q == StInit) || (state_q == StDrain);
    phase_clr = (state_d != state_q);

    unique case (state_q)
      StInit: begin
        hist_wr_en   = 1'b1;
        hist_wr_zero = 1'b1;
        hist_wr_addr = phase_cnt;
      end
      StLoad: begin
        busy         = 1'b0;
        x_rd_en      = pop;
        hist_wr_en   = pop;
        hist_wr_addr = head;
      end
      StMac: begin
        mac_en       = 1'b1;
        mac_clr      = (k == '0);
        coeff_addr   = k;
        // head points one past the newest sample, so tap 0 reads head-1.
        hist_rd_addr = head - ADDR_W'(1) - k;
      end
      StDrain: begin
      end
      StWrite: begin
        y_wr_en = !y_full;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed vector bench for fir_mac_ctrl with a behavioural MAC/RAM datapath
// whose results are compared against a direct decimating FIR computation.
module tb_fir_mac_ctrl;
  import fir_pkg::*;

  localparam int unsigned TAPS = 32;
  localparam int unsigned DEC  = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned AW   = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          x_empty;
  logic          y_full;
  logic          x_rd_en, hist_wr_en, hist_wr_zero, mac_en, mac_clr, y_wr_en, busy;
  logic [AW-1:0] hist_wr_addr, hist_rd_addr, coeff_addr;

  always #5 clock = ~clock;

  fir_mac_ctrl #(
    .TAPS       (TAPS),
    .DECIMATION (DEC),
    .MAC_LAT    (LAT),
    .ADDR_W     (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .x_empty      (x_empty),
    .x_rd_en      (x_rd_en),
    .hist_wr_en   (hist_wr_en),
    .hist_wr_zero (hist_wr_zero),
    .hist_wr_addr (hist_wr_addr),
    .hist_rd_addr (hist_rd_addr),
    .coeff_addr   (coeff_addr),
    .mac_en       (mac_en),
    .mac_clr      (mac_clr),
    .y_full       (y_full),
    .y_wr_en      (y_wr_en),
    .busy         (busy)
  );

  typedef struct {
    logic          rst;
    logic          xe;
    logic          yf;
    logic          rd;
    logic          we;
    logic          wz;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [AW-1:0] ca;
    logic          me;
    logic          mc;
    logic          yw;
    logic          bz;
    string         tag;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  int samples [64];
  int hist    [TAPS];
  int pop_idx = 0;
  int out_idx = 0;
  int n_out   = 0;
  int acc     = 0;
  int p_val   = 0;
  logic p_en  = 1'b0;
  logic p_clr = 1'b0;

  function automatic vec_t mk(input logic rst, input logic xe, input logic yf, input logic rd,
                              input logic we, input logic wz, input int wa, input int ra,
                              input int ca, input logic me, input logic mc, input logic yw,
                              input logic bz, input string tag);
    vec_t v;
    v.rst = rst; v.xe = xe; v.yf = yf; v.rd = rd; v.we = we; v.wz = wz;
    v.wa = AW'(wa & 31); v.ra = AW'(ra & 31); v.ca = AW'(ca & 31);
    v.me = me; v.mc = mc; v.yw = yw; v.bz = bz; v.tag = tag;
    return v;
  endfunction

  function automatic vec_t mac_vec(input int h, input int k);
    return mk(0, 0, 0, 0, 0, 0, 0, h - 1 - k, k, 1, (k == 0), 0, 1, "mac");
  endfunction

  function automatic void add_init();
    for (int a = 0; a < 32; a++) vq.push_back(mk(0, 1, 0, 0, 1, 1, a, 0, 0, 0, 0, 0, 1, "init"));
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle"));
  endfunction

  function automatic void add_pop(input int h);
    vq.push_back(mk(0, 0, 0, 1, 1, 0, h, 0, 0, 0, 0, 0, 0, "load"));
  endfunction

  function automatic void add_output(input int h0, input logic drain_full, input int wait_n);
    for (int i = 0; i < 8; i++) add_pop(h0 + i);
    for (int k = 0; k < 32; k++) vq.push_back(mac_vec(h0 + 8, k));
    for (int i = 0; i < 2; i++)
      vq.push_back(mk(0, 0, drain_full, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "drain"));
    for (int i = 0; i < wait_n; i++)
      vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "wfull"));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "write"));
  endfunction

  function automatic int golden(input int n);
    int s = 0;
    for (int j = 0; j < 32; j++) begin
      if (8 * n - 1 - j >= 0) s += int'(COEFFS[j]) * samples[8 * n - 1 - j];
    end
    return s;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic ok;
    reset = v.rst; x_empty = v.xe; y_full = v.yf;
    #1;
    ok = (x_rd_en == v.rd) && (hist_wr_en == v.we) && (hist_wr_zero == v.wz) &&
         (mac_en == v.me) && (mac_clr == v.mc) && (y_wr_en == v.yw) && (busy == v.bz) &&
         (!v.we || hist_wr_addr == v.wa) &&
         (!v.me || (hist_rd_addr == v.ra && coeff_addr == v.ca));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s#%0d: got rd=%b we=%b wz=%b wa=%0d ra=%0d ca=%0d me=%b mc=%b yw=%b busy=%b want rd=%b we=%b wz=%b wa=%0d ra=%0d ca=%0d me=%b mc=%b yw=%b busy=%b",
               v.tag, idx, x_rd_en, hist_wr_en, hist_wr_zero, hist_wr_addr, hist_rd_addr,
               coeff_addr, mac_en, mac_clr, y_wr_en, busy, v.rd, v.we, v.wz, v.wa, v.ra, v.ca,
               v.me, v.mc, v.yw, v.bz);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_all();
    foreach (vq[i]) run_vec(vq[i], i);
  endtask

  // Behavioural datapath: show-ahead input FIFO, history RAM, 2-stage MAC.
  task automatic model_step();
    int exp_y;
    if (reset) begin
      pop_idx = 0;
      out_idx = 0;
      p_en    = 1'b0;
    end else begin
      if (y_wr_en) begin
        exp_y = golden(out_idx + 1);
        total++;
        if (acc != exp_y) begin
          bad++;
          $display("FAIL result%0d: got %0d want %0d", out_idx + 1, acc, exp_y);
        end
        out_idx++;
        n_out++;
      end
      if (p_en) acc = p_clr ? p_val : acc + p_val;
      p_en  = mac_en;
      p_clr = mac_clr;
      p_val = int'(COEFFS[coeff_addr]) * hist[hist_rd_addr];
      if (hist_wr_en) hist[hist_wr_addr] = hist_wr_zero ? 0 : samples[pop_idx];
      if (x_rd_en) pop_idx++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      model_step();
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) samples[i] = ((i * 37 + 11) % 101) - 50;
    for (int i = 0; i < 32; i++) hist[i] = 7;
    reset = 1'b1; x_empty = 1'b1; y_full = 1'b0;
    @(posedge clock);
    #1;

    // Reset state, zero-fill, idle LOAD, then five outputs with various stalls.
    vq.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "reset"));
    add_init();
    add_idle(3);
    add_output(0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      add_idle(1);
      add_pop(8 + i);
    end
    for (int k = 0; k < 32; k++) vq.push_back(mac_vec(16, k));
    for (int i = 0; i < 2; i++) vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "drain"));
    for (int i = 0; i < 20; i++) vq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "wfull"));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "write"));
    add_output(16, 1'b1, 0);
    add_output(24, 1'b0, 0);
    add_output(0, 1'b0, 0);
    run_all();

    // Reset in the middle of the tap walk, then a fresh output from head 0.
    vq.delete();
    for (int i = 0; i < 8; i++) add_pop(8 + i);
    for (int k = 0; k < 12; k++) vq.push_back(mac_vec(16, k));
    begin
      vec_t v;
      v = mac_vec(16, 12);
      v.rst = 1'b1;
      v.tag = "mac_rst";
      vq.push_back(v);
    end
    add_init();
    add_output(0, 1'b0, 0);
    run_all();

    total++;
    if (n_out != 6) begin
      bad++;
      $display("FAIL out_count: got %0d want 6", n_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
